spike_rate_encoder: RTL
=======================

# spike_rate_encoder

Stochastic rate encoder; consumer of the `rand_gen` LFSR stream.
- Per timestep, walks `NUM_INPUTS` 8-bit intensities from synchronous pixel memory and compares each against the current `rand_gen` output.
- Emits one spike/no-spike decision per input over a valid/ready handshake to the network core.
- Sits between `rand_gen` plus the input buffer and the neuron array.

## Interface
- `NUM_INPUTS`, 16: inputs per timestep; legal range 2..2^`ADDR_W`.
- `ADDR_W`, 4: pixel address and spike index width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: begin one timestep; sampled only in IDLE.
- `rand_i` in 8: `rand_gen` `rand_o`; free-running, sampled in CMP.
- `pix_addr_o` out `ADDR_W`: pixel memory read address.
- `pix_data_i` in 8: pixel intensity; valid one cycle after the address.
- `spike_valid_o` out 1: a spike decision is available.
- `spike_o` out 1: decision, 1 = spike.
- `spike_idx_o` out `ADDR_W`: input index of the decision.
- `spike_ready_i` in 1: consumer accepts the decision.
- `spike_count_o` out `ADDR_W`+1: spikes emitted so far in the current timestep.
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: single-cycle pulse when the timestep completes.

## Operation
- FSM states: IDLE, READ, CMP, OUT, DONE.
- IDLE, `start_i`=1: clear `idx` and `spike_count_o` → READ.
- READ: `pix_addr_o`=`idx` → CMP.
- CMP:
  - `spike_o` ← (`pix_data_i` > `rand_i`), unsigned, strict.
  - `spike_idx_o` ← `idx`.
  - → OUT.
- OUT: `spike_valid_o`=1. `spike_o` and `spike_idx_o` stay stable until `spike_ready_i`=1.
- OUT handshake (`spike_valid_o` & `spike_ready_i`):
  - `spike_count_o` += `spike_o`.
  - If `idx`==`NUM_INPUTS`-1 → DONE.
  - Else `idx`+1 → READ.
- DONE: `done_o`=1 for one cycle → IDLE.
- Comparison outcomes:
  - Intensity 0 never spikes.
  - Intensity 255 spikes unless `rand_i`==255.
  - Equal values do not spike.
- `start_i` outside IDLE is ignored; it is not queued.
- `pix_addr_o` holds its last value outside READ.
- `spike_count_o` holds its final value through IDLE until the next start.
- `spike_count_o` has no overflow: its maximum is `NUM_INPUTS`, which fits in `ADDR_W`+1 bits.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE.
  - `pix_addr_o`, `spike_idx_o`, `spike_count_o` = 0.
  - `spike_valid_o`, `spike_o`, `busy_o`, `done_o` = 0.
- Reset mid-timestep: the sequence is abandoned. There is no resume, and no `done_o` is produced for the aborted step.
- Cycle numbering with `start_i` at cycle 0 and `spike_ready_i` tied high:
  - READ at 1, CMP at 2, OUT at 3.
  - Input k: READ at 3k+1, OUT at 3k+3.
  - `done_o` at cycle 3·`NUM_INPUTS`+1.
  - IDLE at 3·`NUM_INPUTS`+2; earliest accepted restart is that cycle.
- Backpressure: each cycle `spike_ready_i` is low in OUT adds one cycle. No decision is dropped or duplicated.
- `rand_i` is sampled exactly once per input, in CMP. The value present in READ or OUT has no effect.
- `spike_valid_o` is deasserted the cycle after the handshake (state READ or DONE).

## Test plan
- Reset mid-run: pulse `rst` asynchronously at cycle 7.
  - All outputs read 0 immediately.
  - `start_i` in the following cycle restarts at index 0.
- Thresholds, bench-driven `rand_i`=8'h80, `NUM_INPUTS`=4, pixels {8'h00, 8'h80, 8'h81, 8'hFF}:
  - `spike_o` sequence 0,0,1,1; `spike_idx_o` 0..3.
  - `spike_count_o`=2.
  - `done_o` at cycle 13.
- Backpressure: hold `spike_ready_i` low for 5 cycles on index 1.
  - `spike_valid_o`, `spike_o`, `spike_idx_o` stay stable.
  - `done_o` is delayed by exactly 5 cycles.
  - Exactly 4 handshakes occur.
- Ignored start: assert `start_i` at cycles 2 and 5 of a running timestep.
  - Only one timestep runs.
  - `busy_o` stays high until `done_o`, then drops.
- Statistics with real `rand_gen` (reset seed), `NUM_INPUTS`=16, all pixels 8'h40, 256 timesteps:
  - Spike rate is within 25% ±3% (about 63/255).
  - All-8'h00 gives zero spikes.
  - All-8'hFF gives rate ≥ 99%.
- Back-to-back: assert `start_i` in the first IDLE cycle after `done_o`.
  - The second timestep starts with no gap.
  - `spike_count_o` clears to 0 before the first READ.

Source files
------------

// File: rtl/spike_rate_encoder.sv
// rtl/spike_rate_encoder.sv - stochastic rate encoder: pixel intensity vs random value -> spike stream
//
// Purpose
//   For each timestep, walks NUM_INPUTS pixel intensities from a synchronous
//   pixel memory and compares each one against the rand_gen value. Each
//   spike/no-spike decision goes to the network core over a valid/ready
//   handshake. A pixel spikes when its intensity is strictly greater than
//   the random value, so the spike rate approximates intensity/256.
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-high reset
//   start_i        in   begin one timestep (sampled only while idle)
//   rand_i         in   free-running random byte, sampled once per input
//   pix_addr_o     out  pixel memory read address
//   pix_data_i     in   pixel intensity, valid one cycle after the address
//   spike_valid_o  out  a spike decision is available
//   spike_o        out  decision, 1 = spike
//   spike_idx_o    out  input index of the decision
//   spike_ready_i  in   consumer accepts the decision
//   spike_count_o  out  spikes emitted so far in the current timestep
//   busy_o         out  high whenever a timestep is in progress
//   done_o         out  one-cycle pulse when the timestep completes

module spike_rate_encoder #(
    parameter int NUM_INPUTS = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        rand_i,
    output logic [ADDR_W-1:0] pix_addr_o,
    input  logic [7:0]        pix_data_i,
    output logic              spike_valid_o,
    output logic              spike_o,
    output logic [ADDR_W-1:0] spike_idx_o,
    input  logic              spike_ready_i,
    output logic [ADDR_W:0]   spike_count_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_INPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_OUT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_pix_addr;
    logic                r_spike;
    logic [ADDR_W-1:0]   r_spike_idx;
    logic [ADDR_W:0]     r_count;

    logic                w_handshake;
    logic                w_last;
    logic                w_spike_new;

    assign w_handshake = (r_state == S_OUT) && spike_ready_i;
    assign w_last      = (r_idx == LAST_IDX);
    // Strict unsigned compare: intensity 0 never spikes, 255 spikes unless
    // the random byte is also 255, equal values never spike.
    assign w_spike_new = (pix_data_i > rand_i);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                w_state_next = S_CMP;
            end
            S_CMP: begin
                w_state_next = S_OUT;
            end
            S_OUT: begin
                if (w_handshake) begin
                    w_state_next = w_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // The read address is loaded on the way into READ so it already shows
    // the index during READ and then simply holds until the next READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_pix_addr  <= '0;
            r_spike     <= 1'b0;
            r_spike_idx <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_idx      <= '0;
                        r_pix_addr <= '0;
                        r_count    <= '0;
                    end
                end
                S_CMP: begin
                    // Pixel data for r_idx arrives here, one cycle after READ.
                    r_spike     <= w_spike_new;
                    r_spike_idx <= r_idx;
                end
                S_OUT: begin
                    if (w_handshake) begin
                        r_count <= r_count + (ADDR_W + 1)'(r_spike);
                        if (!w_last) begin
                            r_idx      <= r_idx + 1'b1;
                            r_pix_addr <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pix_addr_o    = r_pix_addr;
    assign spike_o       = r_spike;
    assign spike_idx_o   = r_spike_idx;
    assign spike_count_o = r_count;
    assign spike_valid_o = (r_state == S_OUT);
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_DONE);

endmodule
